seq_code_lock: RTL and testbench

- Parametrised successor of the fixed 5-symbol binary lock FSM.
- Accepts a serial stream of keyed bits and compares each against a programmable code of CODE_LEN bits, MSB first.
- Asserts unlock for a configurable pulse width on a correct code.
- Counts failed attempts, enters a timed alarm lockout after MAX_FAIL failures, and abandons stale partial entries after an inactivity timeout.
- Sits between the key-input debouncer and the door-actuator/alarm logic.

---
 rtl/seq_code_lock.sv | 177 +++++++++++++++++
 tb/tb_seq_code_lock.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/seq_code_lock.sv
// seq_code_lock: serial binary code lock.
//
// Keyed bits arrive one per key_valid cycle and are compared, MSB first,
// against a programmable CODE_LEN-bit code. A full correct entry opens the
// lock with an unlock pulse of UNLOCK_CYCLES cycles. MAX_FAIL consecutive
// wrong entries raise alarm for LOCKOUT_CYCLES cycles, during which every
// input except reset is ignored. A partial entry left idle for
// TIMEOUT_CYCLES cycles is discarded without counting as a failure.
//
// Handshake: key_valid and code_load are single-cycle qualifiers with no
// back-pressure. A key is consumed on the rising edge where key_valid=1 and
// the lock is in ENTER. It is dropped, not held, when the lock is in UNLOCK
// or LOCKOUT, or when code_load is high on the same edge.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous, active-low reset
//   key_valid  one key press this cycle
//   key_bit    value of the pressed key
//   code_load  load code_in as the new code (ENTER/UNLOCK only)
//   code_in    new code, MSB entered first
//   unlock     registered open pulse
//   alarm      registered, high while in LOCKOUT
//   progress   number of code bits matched so far
//   fail_cnt   consecutive failed attempts
//   dbg_state  current FSM state (0=ENTER, 1=UNLOCK, 2=LOCKOUT)
module seq_code_lock #(
  parameter int                  CODE_LEN       = 5,
  parameter logic [CODE_LEN-1:0] RESET_CODE     = 5'b01011,
  parameter int                  MAX_FAIL       = 3,
  parameter int                  LOCKOUT_CYCLES = 16,
  parameter int                  UNLOCK_CYCLES  = 2,
  parameter int                  TIMEOUT_CYCLES = 8
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                key_valid,
  input  logic                                key_bit,
  input  logic                                code_load,
  input  logic [CODE_LEN-1:0]                 code_in,
  output logic                                unlock,
  output logic                                alarm,
  output logic [$clog2(CODE_LEN+1)-1:0]       progress,
  output logic [$clog2(MAX_FAIL+1)-1:0]       fail_cnt,
  output logic [1:0]                          dbg_state
);

  localparam int PW      = $clog2(CODE_LEN + 1);
  localparam int FW      = $clog2(MAX_FAIL + 1);
  localparam int TW      = $clog2(TIMEOUT_CYCLES + 1);
  localparam int CNT_MAX = (LOCKOUT_CYCLES > UNLOCK_CYCLES) ? LOCKOUT_CYCLES : UNLOCK_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);

  localparam logic [CODE_LEN-1:0] MSB_ONE = {1'b1, {(CODE_LEN-1){1'b0}}};

  typedef enum logic [1:0] {
    S_ENTER   = 2'd0,
    S_UNLOCK  = 2'd1,
    S_LOCKOUT = 2'd2
  } state_t;

  state_t              state, state_n;
  logic [PW-1:0]       prog_n;
  logic [FW-1:0]       fail_n;
  logic [CODE_LEN-1:0] code, code_n;
  logic [TW-1:0]       timer, timer_n;
  logic [CW-1:0]       cnt, cnt_n;
  logic                exp_bit;

  // Code bit expected next: select bit CODE_LEN-1-progress by walking a
  // one-hot mask down from the MSB.
  assign exp_bit   = |(code & (MSB_ONE >> progress));
  assign dbg_state = state;

  always_comb begin
    state_n = state;
    prog_n  = progress;
    fail_n  = fail_cnt;
    code_n  = code;
    timer_n = timer;
    cnt_n   = cnt;

    case (state)
      S_ENTER: begin
        if (code_load) begin
          // A key arriving with a code load is discarded entirely.
          code_n  = code_in;
          prog_n  = '0;
          timer_n = '0;
        end else if (key_valid) begin
          timer_n = '0;
          if (key_bit == exp_bit) begin
            if (progress == PW'(CODE_LEN - 1)) begin
              prog_n  = '0;
              cnt_n   = '0;
              state_n = S_UNLOCK;
            end else begin
              prog_n = progress + PW'(1);
            end
          end else begin
            // The wrong bit is consumed; matching restarts on the next key.
            prog_n = '0;
            fail_n = fail_cnt + FW'(1);
            if (fail_cnt == FW'(MAX_FAIL - 1)) begin
              cnt_n   = '0;
              state_n = S_LOCKOUT;
            end
          end
        end else if (progress != '0) begin
          if (timer == TW'(TIMEOUT_CYCLES - 1)) begin
            prog_n  = '0;
            timer_n = '0;
          end else begin
            timer_n = timer + TW'(1);
          end
        end
      end

      S_UNLOCK: begin
        if (code_load) begin
          code_n  = code_in;
          prog_n  = '0;
          timer_n = '0;
        end
        if (cnt == CW'(UNLOCK_CYCLES - 1)) begin
          cnt_n   = '0;
          fail_n  = '0;
          state_n = S_ENTER;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end

      S_LOCKOUT: begin
        if (cnt == CW'(LOCKOUT_CYCLES - 1)) begin
          cnt_n   = '0;
          fail_n  = '0;
          prog_n  = '0;
          state_n = S_ENTER;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end

      default: begin
        state_n = S_ENTER;
        prog_n  = '0;
        cnt_n   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= S_ENTER;
      progress <= '0;
      fail_cnt <= '0;
      code     <= RESET_CODE;
      timer    <= '0;
      cnt      <= '0;
      unlock   <= 1'b0;
      alarm    <= 1'b0;
    end else begin
      state    <= state_n;
      progress <= prog_n;
      fail_cnt <= fail_n;
      code     <= code_n;
      timer    <= timer_n;
      cnt      <= cnt_n;
      // Decoded from the next state so both flags are true flops that
      // line up exactly with the state they describe.
      unlock   <= (state_n == S_UNLOCK);
      alarm    <= (state_n == S_LOCKOUT);
    end
  end

endmodule

// File: tb/tb_seq_code_lock.sv
// Testbench for seq_code_lock with default parameters.
// Inputs are driven on the falling edge. Every driven cycle, a reference
// model pushes the expected post-edge outputs into exp_q. A monitor pops
// one entry 1ns after each rising edge and compares it with the DUT.
module tb_seq_code_lock;

  localparam int CODE_LEN = 5;
  localparam int PW       = 3;
  localparam int FW       = 2;
  localparam int W        = 2 + 1 + 1 + PW + FW;

  // clock / reset
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic                key_valid, key_bit, code_load;
  logic [CODE_LEN-1:0] code_in;
  logic                unlock, alarm;
  logic [PW-1:0]       progress;
  logic [FW-1:0]       fail_cnt;
  logic [1:0]          dbg_state;

  seq_code_lock dut (
    .clk       (clk),
    .reset     (reset),
    .key_valid (key_valid),
    .key_bit   (key_bit),
    .code_load (code_load),
    .code_in   (code_in),
    .unlock    (unlock),
    .alarm     (alarm),
    .progress  (progress),
    .fail_cnt  (fail_cnt),
    .dbg_state (dbg_state)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model, written directly from the behavioural description.
  // m_st: 0=ENTER 1=UNLOCK 2=LOCKOUT
  int                  m_st, m_prog, m_fail, m_timer, m_left;
  logic [CODE_LEN-1:0] m_code;

  task automatic model_reset();
    m_st = 0; m_prog = 0; m_fail = 0; m_timer = 0; m_left = 0;
    m_code = 5'b01011;
  endtask

  logic [W-1:0] exp_q[$];

  task automatic model_step(input logic kv, input logic kb, input logic cl,
                            input logic [CODE_LEN-1:0] ci);
    logic [W-1:0] e;
    if (m_st == 0) begin
      if (cl) begin
        m_code = ci; m_prog = 0; m_timer = 0;
      end else if (kv) begin
        m_timer = 0;
        if (kb == m_code[CODE_LEN-1-m_prog]) begin
          m_prog = m_prog + 1;
          if (m_prog == CODE_LEN) begin
            m_prog = 0; m_st = 1; m_left = 2;
          end
        end else begin
          m_prog = 0;
          m_fail = m_fail + 1;
          if (m_fail == 3) begin
            m_st = 2; m_left = 16;
          end
        end
      end else if (m_prog > 0) begin
        m_timer = m_timer + 1;
        if (m_timer == 8) begin
          m_prog = 0; m_timer = 0;
        end
      end
    end else if (m_st == 1) begin
      if (cl) begin
        m_code = ci; m_prog = 0; m_timer = 0;
      end
      // m_left counts the unlock cycles still to be shown, this one included.
      m_left = m_left - 1;
      if (m_left == 0) begin
        m_st = 0; m_fail = 0;
      end
    end else begin
      m_left = m_left - 1;
      if (m_left == 0) begin
        m_st = 0; m_fail = 0; m_prog = 0;
      end
    end
    e = {2'(m_st), (m_st == 1), (m_st == 2), PW'(m_prog), FW'(m_fail)};
    exp_q.push_back(e);
  endtask

  // driver tasks
  task automatic drive(input logic kv, input logic kb, input logic cl,
                       input logic [CODE_LEN-1:0] ci);
    @(negedge clk);
    key_valid = kv; key_bit = kb; code_load = cl; code_in = ci;
    model_step(kv, kb, cl, ci);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, '0);
  endtask

  task automatic key(input logic b);
    drive(1'b1, b, 1'b0, '0);
  endtask

  task automatic enter_code(input logic [CODE_LEN-1:0] c, input int gap);
    for (int i = CODE_LEN - 1; i >= 0; i--) begin
      key(c[i]);
      if (gap > 0 && i > 0) idle(gap);
    end
  endtask

  // scoreboard monitor
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      logic [W-1:0] e;
      e = exp_q.pop_front();
      check("state",    dbg_state, e[W-1 -: 2]);
      check("unlock",   unlock,    e[PW+FW+1]);
      check("alarm",    alarm,     e[PW+FW]);
      check("progress", progress,  e[FW +: PW]);
      check("fail_cnt", fail_cnt,  e[FW-1:0]);
    end
  end

  initial begin
    reset = 1'b0;
    key_valid = 1'b0; key_bit = 1'b0; code_load = 1'b0; code_in = '0;
    model_reset();
    #2;
    check("rst_unlock",   unlock,    0);
    check("rst_alarm",    alarm,     0);
    check("rst_progress", progress,  0);
    check("rst_fail",     fail_cnt,  0);
    check("rst_state",    dbg_state, 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;

    // Correct code on consecutive cycles.
    enter_code(5'b01011, 0);
    idle(3);

    // Three bad attempts -> lockout; keys and loads during alarm are ignored.
    for (int a = 0; a < 3; a++) begin
      key(1'b0); key(1'b1); key(1'b1);
    end
    for (int i = 0; i < 16; i++)
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)));
    idle(1);
    enter_code(5'b01011, 0);
    idle(3);

    // Partial entry abandoned by timeout, not counted as a failure.
    key(1'b0); key(1'b1);
    idle(9);
    enter_code(5'b01011, 0);
    idle(3);

    // Idle gaps shorter than the timeout keep progress.
    enter_code(5'b01011, 3);
    idle(3);

    // Code load with a simultaneous key, then old code fails, new code opens.
    drive(1'b1, 1'b1, 1'b1, 5'b11100);
    enter_code(5'b01011, 0);
    idle(9);
    enter_code(5'b11100, 0);
    idle(3);

    // Code load during the unlock pulse: pulse finishes, new code applies.
    enter_code(5'b11100, 0);
    drive(1'b1, 1'b0, 1'b1, 5'b10101);
    idle(2);
    enter_code(5'b10101, 0);
    idle(3);

    // Random traffic with occasional code loads.
    for (int i = 0; i < 200; i++)
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 15) == 0), 5'($urandom_range(0, 31)));
    idle(20);

    // Reach lockout, then assert reset in the third lockout cycle.
    drive(1'b1, 1'b0, 1'b1, 5'b11111);
    key(1'b0); key(1'b0); key(1'b0);
    idle(2);
    @(posedge clk);
    #3;
    reset = 1'b0;
    key_valid = 1'b0; key_bit = 1'b0; code_load = 1'b0; code_in = '0;
    #1;
    check("async_alarm",    alarm,     0);
    check("async_fail",     fail_cnt,  0);
    check("async_progress", progress,  0);
    check("async_unlock",   unlock,    0);
    check("async_state",    dbg_state, 0);
    model_reset();
    exp_q.delete();
    @(negedge clk);
    reset = 1'b1;

    // Code reverted to the reset value.
    enter_code(5'b01011, 0);
    idle(3);

    @(posedge clk);
    #2;
    check("drain", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
